// File: rtl/vend_motor_if.sv
// Handshake bundle between the code-entry FSM and the vending motor controller.
interface vend_motor_if #(
    parameter int unsigned NUM_MOTORS = 8
);
    logic                  start;
    logic [2:0]            slot;
    logic                  abort;
    logic                  drop_sensed;
    logic                  clear_fault;
    logic [NUM_MOTORS-1:0] motor;
    logic                  busy;
    logic                  done;
    logic                  fault;
    logic                  reject;

    modport master (
        output start, slot, abort, drop_sensed, clear_fault,
        input  motor, busy, done, fault, reject
    );

    modport slave (
        input  start, slot, abort, drop_sensed, clear_fault,
        output motor, busy, done, fault, reject
    );
endinterface

// File: rtl/vend_motor_ctrl.sv
// Runs one vending motor per accepted code until the drop sensor fires or the
// run times out, then enforces a cool-down; a timeout latches a sticky fault.
module vend_motor_ctrl #(
    parameter int unsigned NUM_MOTORS = 8,
    parameter int unsigned RUN_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES = 12_500_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    vend_motor_if.slave bus
);

    localparam int unsigned SLOT_W = 3;
    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        COOL  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sync1_q, drop_s;
    logic [NUM_MOTORS-1:0] motor_q, motor_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                reject_q, reject_d;
    logic                slot_ok_c;

    assign slot_ok_c = ({1'b0, bus.slot} < 4'(NUM_MOTORS));

    // State, counter, synchronizer and output registers; reset drops motors at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            slot_q   <= '0;
            sync1_q  <= 1'b0;
            drop_s   <= 1'b0;
            motor_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            sync1_q  <= bus.drop_sensed;
            drop_s   <= sync1_q;
            motor_q  <= motor_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            reject_q <= reject_d;
        end
    end

    // Next state; within RUN a drop wins over abort, which wins over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (bus.start && slot_ok_c) begin
                    slot_d  = bus.slot;
                    cnt_d   = RUN_LOAD;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (drop_s || bus.abort) begin
                    cnt_d   = GAP_LOAD;
                    state_d = COOL;
                end else if (cnt_q == '0) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FAULT: begin
                if (bus.clear_fault) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        motor_d  = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        reject_d = 1'b0;
        if (state_d == RUN) begin
            motor_d = NUM_MOTORS'(1) << slot_d;
        end
        busy_d   = (state_d != IDLE);
        fault_d  = (state_d == FAULT);
        done_d   = (state_q == RUN) && drop_s;
        reject_d = (state_q == IDLE) && bus.start && !slot_ok_c;
    end

    assign bus.motor  = motor_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.fault  = fault_q;
    assign bus.reject = reject_q;

endmodule

// File: tb/tb_vend_motor_ctrl.sv
// Self-checking bench for vend_motor_ctrl: directed vector table, corner-case
// sequences and random stimulus against a cycle-count reference model.
module tb_vend_motor_ctrl;

    localparam int unsigned NM = 6;
    localparam int unsigned RC = 10;
    localparam int unsigned GC = 4;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n;

    vend_motor_if #(.NUM_MOTORS(NM)) bus ();

    vend_motor_ctrl #(
        .NUM_MOTORS(NM),
        .RUN_CYCLES(RC),
        .GAP_CYCLES(GC),
        .CNT_W     (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 cooling, 3 faulted; time counted upward.
    int m_mode, m_slot, m_on, m_cool;
    bit dq[$];
    logic [NM-1:0] e_motor;
    bit e_busy, e_done, e_fault, e_reject;

    typedef struct {
        bit st; int sl; bit ab; bit dr; bit cl;
        logic [NM-1:0] motor; bit busy; bit done; bit fault; bit reject;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit st, int sl, bit ab, bit dr, bit cl,
                                logic [NM-1:0] mo, bit bu, bit dn, bit fa, bit rj);
        vec_t v;
        v.st = st; v.sl = sl; v.ab = ab; v.dr = dr; v.cl = cl;
        v.motor = mo; v.busy = bu; v.done = dn; v.fault = fa; v.reject = rj;
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_slot = 0; m_on = 0; m_cool = 0;
        dq.delete();
        dq.push_back(1'b0);
        dq.push_back(1'b0);
        e_motor = '0; e_busy = 0; e_done = 0; e_fault = 0; e_reject = 0;
    endfunction

    function automatic void model_step(bit st, int sl, bit ab, bit dr_in, bit cl);
        bit ds;
        ds = dq.pop_front();
        dq.push_back(dr_in);
        e_done = 0;
        e_reject = 0;
        case (m_mode)
            0: if (st) begin
                   if (sl < int'(NM)) begin
                       m_mode = 1; m_slot = sl; m_on = 0;
                   end else begin
                       e_reject = 1;
                   end
               end
            1: begin
                   m_on++;
                   if (ds) begin
                       e_done = 1; m_mode = 2; m_cool = 0;
                   end else if (ab) begin
                       m_mode = 2; m_cool = 0;
                   end else if (m_on == int'(RC)) begin
                       m_mode = 3;
                   end
               end
            2: begin
                   m_cool++;
                   if (m_cool == int'(GC)) m_mode = 0;
               end
            default: if (cl) m_mode = 0;
        endcase
        e_motor = '0;
        if (m_mode == 1) e_motor[m_slot] = 1'b1;
        e_busy  = (m_mode != 0);
        e_fault = (m_mode == 3);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit st, int sl, bit ab, bit dr, bit cl);
        bus.start       = st;
        bus.slot        = 3'(sl);
        bus.abort       = ab;
        bus.drop_sensed = dr;
        bus.clear_fault = cl;
    endtask

    task automatic cmp_model(string tag);
        chk({tag, ".motor"},  int'(bus.motor),  int'(e_motor));
        chk({tag, ".busy"},   int'(bus.busy),   int'(e_busy));
        chk({tag, ".done"},   int'(bus.done),   int'(e_done));
        chk({tag, ".fault"},  int'(bus.fault),  int'(e_fault));
        chk({tag, ".reject"}, int'(bus.reject), int'(e_reject));
    endtask

    task automatic cycle(string tag, bit st, int sl, bit ab, bit dr, bit cl);
        drive(st, sl, ab, dr, cl);
        @(posedge clk);
        model_step(st, sl, ab, dr, cl);
        #1;
        cmp_model(tag);
    endtask

    initial begin
        int on_cnt;

        // Directed table: reject, vend with drop, busy-ignore, COOL->IDLE start, abort.
        tbl[0]  = mk(1, 7, 0, 0, 0, 6'b000000, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, 0, 0, 0, 6'b000100, 1, 0, 0, 0);
        tbl[3]  = mk(1, 4, 0, 0, 0, 6'b000100, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 6'b000100, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 6'b000100, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 6'b000000, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 6'b000010, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 6'b000000, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 6'b000000, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
        tbl[17] = mk(1, 6, 0, 0, 0, 6'b000000, 0, 0, 0, 1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.motor",  int'(bus.motor),  0);
        chk("rst.busy",   int'(bus.busy),   0);
        chk("rst.done",   int'(bus.done),   0);
        chk("rst.fault",  int'(bus.fault),  0);
        chk("rst.reject", int'(bus.reject), 0);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sl, tbl[i].ab, tbl[i].dr, tbl[i].cl);
            @(posedge clk);
            model_step(tbl[i].st, tbl[i].sl, tbl[i].ab, tbl[i].dr, tbl[i].cl);
            #1;
            chk($sformatf("tbl%0d.motor", i),  int'(bus.motor),  int'(tbl[i].motor));
            chk($sformatf("tbl%0d.busy", i),   int'(bus.busy),   int'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i),   int'(bus.done),   int'(tbl[i].done));
            chk($sformatf("tbl%0d.fault", i),  int'(bus.fault),  int'(tbl[i].fault));
            chk($sformatf("tbl%0d.reject", i), int'(bus.reject), int'(tbl[i].reject));
        end

        // Timeout: motor on for exactly RC cycles, then sticky fault.
        cycle("to_start", 1, 0, 0, 0, 0);
        on_cnt = int'(bus.motor[0]);
        for (int i = 0; i < int'(RC); i++) begin
            cycle("to_run", 0, 0, 0, 0, 0);
            on_cnt += int'(bus.motor[0]);
        end
        chk("timeout_on_cycles", on_cnt, int'(RC));
        chk("timeout_fault", int'(bus.fault), 1);
        chk("timeout_busy", int'(bus.busy), 1);
        cycle("fault_start_ignored", 1, 3, 0, 0, 0);
        chk("fault_no_reject", int'(bus.reject), 0);
        cycle("fault_clear", 0, 0, 0, 0, 1);
        cycle("after_clear_start", 1, 3, 0, 0, 0);
        chk("after_clear_motor", int'(bus.motor), 8);

        // Async reset between edges during RUN.
        cycle("pre_reset_run", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.motor", int'(bus.motor), 0);
        chk("async_rst.busy",  int'(bus.busy),  0);
        model_reset();
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle("post_reset_idle", 0, 0, 0, 0, 0);

        // Drop and abort land in the same RUN cycle: success wins.
        cycle("da_start", 1, 4, 0, 0, 0);
        cycle("da_1", 0, 0, 0, 1, 0);
        cycle("da_2", 0, 0, 0, 0, 0);
        cycle("da_3", 0, 0, 1, 0, 0);
        chk("drop_abort_done", int'(bus.done), 1);
        repeat (GC) cycle("da_cool", 0, 0, 0, 0, 0);
        chk("da_cool_end_busy", int'(bus.busy), 0);

        // Drop seen on the final timeout cycle: success, no fault.
        cycle("dt_start", 1, 1, 0, 0, 0);
        for (int i = 1; i <= int'(RC); i++) begin
            cycle("dt_run", 0, 0, 0, (i == int'(RC) - 2), 0);
        end
        chk("drop_at_timeout_done", int'(bus.done), 1);
        chk("drop_at_timeout_fault", int'(bus.fault), 0);
        repeat (GC) cycle("dt_cool", 0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle("rand",
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
